// File: rtl/vip_stream_pkg.sv
// Shared types and constants for the vip_stream_tx video transmitter:
// frame-phase state encoding, RGB888 pixel type, colour-bar table and
// counter-sizing helpers.
package vip_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vip_stream_tx_if.sv
// Upstream pixel source handshake (valid/ready) feeding vip_stream_tx.
// master: the pixel source; slave: the transmitter that consumes pixels.
interface vip_stream_tx_if;
    import vip_stream_pkg::*;

    logic    src_valid;
    rgb888_t src_data;
    logic    src_ready;

    modport master (output src_valid, output src_data, input src_ready);
    modport slave  (input src_valid, input src_data, output src_ready);

endinterface

// File: rtl/vip_color_bar.sv
// Eight vertical colour bars, each H_ACTIVE/8 pixels wide with the last bar
// absorbing any remainder. Only compiled when VIP_STREAM_TX_PATTERN_EN is defined.
`ifdef VIP_STREAM_TX_PATTERN_EN
module vip_color_bar
    import vip_stream_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int HW       = 10
) (
    input  logic [HW-1:0] h_cnt,
    input  logic          active,
    output rgb888_t       pixel
);

    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    int unsigned bar_q;
    logic [2:0]  bar_idx;

    // Map the pixel column to a bar, clamping the remainder into the last bar
    always_comb begin
        bar_q   = 32'(h_cnt) / 32'(BAR_W);
        bar_idx = (bar_q > 32'd7) ? 3'd7 : 3'(bar_q);
        pixel   = active ? rgb888_t'(BAR_COLORS[bar_idx]) : '0;
    end

endmodule
`endif

// File: rtl/vip_stream_tx.sv
// Video stream transmitter: wraps pixels pulled from a valid/ready source in
// programmable vertical/horizontal blanking and emits a free-running
// vsync/href/clken/RGB888 stream with one-cycle registered latency.
// Optional colour-bar generator is built when VIP_STREAM_TX_PATTERN_EN is defined.
module vip_stream_tx
    import vip_stream_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  pattern_en,
    vip_stream_tx_if.slave        src,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output rgb888_t               post_img,
    output logic                  frame_done,
    output logic                  underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_MAX   = max4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_MAX);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PIX  = HW'(H_ACTIVE);

    state_t        state, state_next;
    logic [HW-1:0] h_cnt, h_next;
    logic [VW-1:0] v_cnt, v_next, v_last;
    logic          h_wrap, line_last;
    logic          frame_end, frame_start;
    logic          pix_slot, pattern_mode, src_ready_int;
    rgb888_t       img_next;

    assign h_wrap    = (h_cnt == H_LAST);
    assign line_last = (v_cnt == v_last);
    assign pix_slot  = (state == ST_ACTIVE) && (h_cnt < H_PIX);

    assign src_ready_int = pix_slot & ~pattern_mode;
    assign src.src_ready = src_ready_int;

    // Last line index of the phase currently being played out
    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:  v_last = VW'(V_SYNC - 1);
            ST_VBACK:  v_last = VW'(V_BACK - 1);
            ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            ST_VFRONT: v_last = VW'(V_FRONT - 1);
            default:   v_last = '0;
        endcase
    end

    // Phase sequencing and raster counters; enable is only looked at in IDLE
    // and on the wrap that closes a frame
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        h_next      = h_cnt;
        v_next      = v_cnt;
        frame_end   = 1'b0;
        frame_start = 1'b0;
        if (state == ST_IDLE) begin
            if (enable) begin
                state_next  = ST_VSYNC;
                frame_start = 1'b1;
                h_next      = '0;
                v_next      = '0;
            end
        end else begin
            h_next = h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                if (line_last) begin
                    v_next = '0;
                    case (state)
                        ST_VSYNC:  state_next = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
                        ST_VBACK:  state_next = ST_ACTIVE;
                        ST_ACTIVE: begin
                            if (V_FRONT > 0) state_next = ST_VFRONT;
                            else             frame_end  = 1'b1;
                        end
                        ST_VFRONT: frame_end  = 1'b1;
                        default:   state_next = ST_IDLE;
                    endcase
                    if (frame_end) begin
                        state_next  = enable ? ST_VSYNC : ST_IDLE;
                        frame_start = enable;
                    end
                end else begin
                    v_next = v_cnt + 1'b1;
                end
            end
        end
    end

    // Phase and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

`ifdef VIP_STREAM_TX_PATTERN_EN
    logic    pattern_q;
    rgb888_t bar_pix;

    // Capture the pattern selection once per frame so a frame is never mixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pattern_q <= 1'b0;
        else if (frame_start) pattern_q <= pattern_en;
    end

    assign pattern_mode = pattern_q;

    vip_color_bar #(
        .H_ACTIVE (H_ACTIVE),
        .HW       (HW)
    ) u_color_bar (
        .h_cnt  (h_cnt),
        .active (pix_slot),
        .pixel  (bar_pix)
    );
`else
    logic unused_pattern_en;
    logic unused_frame_start;

    assign unused_pattern_en  = pattern_en;
    assign unused_frame_start = frame_start;
    assign pattern_mode       = 1'b0;
`endif

    // Pixel for the next output cycle: source data, zero on underflow or blanking
    always_comb begin
        img_next = '0;
        if (src_ready_int && src.src_valid) img_next = src.src_data;
`ifdef VIP_STREAM_TX_PATTERN_EN
        if (pattern_mode) img_next = bar_pix;
`endif
    end

    // Registered stream outputs, one cycle behind the counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img         <= '0;
            frame_done       <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            post_frame_vsync <= (state == ST_VSYNC);
            post_frame_href  <= pix_slot;
            post_frame_clken <= pix_slot;
            post_img         <= img_next;
            frame_done       <= frame_end;
            underflow        <= src_ready_int & ~src.src_valid;
        end
    end

endmodule

// File: tb/tb_vip_stream_tx.sv
// Self-checking bench for vip_stream_tx: a frame-position reference model
// predicts the stream and pushes expected pixels into a scoreboard queue that
// a separate monitor drains whenever clken is high.
`timescale 1ns/1ps
module tb_vip_stream_tx;
    import vip_stream_pkg::*;

    localparam int HA = 4, HB = 2, VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int HT    = HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * HT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pattern_en = 1'b0;
    logic        vsync, href, clken, fd, uf;
    logic [23:0] img;

    vip_stream_tx_if src_if();

    vip_stream_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS),
        .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .pattern_en       (pattern_en),
        .src              (src_if),
        .post_frame_vsync (vsync),
        .post_frame_href  (href),
        .post_frame_clken (clken),
        .post_img         (img),
        .frame_done       (fd),
        .underflow        (uf)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus: pixel source ----------------
    int          valid_mode = 0;   // 0: always valid, 1: random, 2: one directed drop
    int          drop_idx = -1;
    int          slot_cnt = 0;
    logic [23:0] drv_data = 24'h1;

    initial begin : driver
        logic hs, was_slot;
        src_if.src_valid = 1'b0;
        src_if.src_data  = 24'h1;
        forever begin
            @(negedge clk);
            hs       = src_if.src_valid && src_if.src_ready;
            was_slot = src_if.src_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                drv_data = 24'h1;
            end else begin
                if (hs)       drv_data = drv_data + 24'h1;
                if (was_slot) slot_cnt++;
            end
            case (valid_mode)
                1:       src_if.src_valid = ($urandom_range(0, 3) != 0);
                2:       src_if.src_valid = (slot_cnt != drop_idx);
                default: src_if.src_valid = 1'b1;
            endcase
            src_if.src_data = drv_data;
        end
    end

    // ---------------- reference model + scoreboard producer ----------------
    typedef struct {
        logic [23:0] pix;
        logic        uf;
    } exp_t;
    exp_t exp_q[$];

    bit m_run = 1'b0;
    int m_p = 0;
    bit exp_vs = 1'b0, exp_href = 1'b0, exp_fd = 1'b0;

    initial forever begin : model
        int  line, col;
        bit  slot;
        @(negedge clk);
        if (!rst_n) begin
            check("reset_vsync", vsync, 0);
            check("reset_href", href, 0);
            check("reset_clken", clken, 0);
            check("reset_img", img, 0);
            check("reset_frame_done", fd, 0);
            check("reset_underflow", uf, 0);
            check("reset_src_ready", src_if.src_ready, 0);
            m_run = 1'b0; m_p = 0;
            exp_vs = 1'b0; exp_href = 1'b0; exp_fd = 1'b0;
            exp_q.delete();
        end else begin
            check("vsync", vsync, exp_vs);
            check("href", href, exp_href);
            check("clken", clken, exp_href);
            check("frame_done", fd, exp_fd);
            line = m_p / HT;
            col  = m_p % HT;
            slot = m_run && (line >= VS + VB) && (line < VS + VB + VA) && (col < HA);
            check("src_ready", src_if.src_ready, slot);
            exp_vs   = m_run && (line < VS);
            exp_href = slot;
            exp_fd   = m_run && (m_p == FRAME - 1);
            if (slot)
                exp_q.push_back('{pix: (src_if.src_valid ? src_if.src_data : 24'h0),
                                  uf:  !src_if.src_valid});
            if (!m_run) begin
                if (enable) begin m_run = 1'b1; m_p = 0; end
            end else if (m_p == FRAME - 1) begin
                if (enable) m_p = 0;
                else        m_run = 1'b0;
            end else begin
                m_p++;
            end
        end
    end

    // ---------------- monitor: scoreboard consumer ----------------
    initial forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (clken) begin
                check("pixel_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pixel", img, e.pix);
                    check("underflow_on_pixel", uf, e.uf);
                end
            end else begin
                check("blank_img", img, 0);
                check("blank_underflow", uf, 0);
            end
        end
    end

    // ---------------- event tracker ----------------
    int   vs_rises = 0, vs_high = 0, pix_total = 0, uf_total = 0, fd_total = 0;
    int   rise_last = 0, rise_prev = 0, fd_cyc = 0;
    logic [23:0] last_pix = '0;
    logic vs_prev = 1'b0;

    initial forever begin : tracker
        @(negedge clk);
        if (vsync && !vs_prev) begin
            vs_rises++;
            rise_prev = rise_last;
            rise_last = cyc;
        end
        vs_prev = vsync;
        if (vsync) vs_high++;
        if (clken) begin pix_total++; last_pix = img; end
        if (uf)    uf_total++;
        if (fd)    begin fd_total++; fd_cyc = cyc; end
    end

`ifdef VIP_STREAM_TX_PATTERN_EN
    // ---------------- pattern-mode instance ----------------
    localparam int PHA = 16;
    logic        p_vs, p_href, p_clken, p_fd, p_uf;
    logic [23:0] p_img;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    vip_stream_tx_if p_if();
    assign p_if.src_valid = 1'b0;
    assign p_if.src_data  = '0;

    vip_stream_tx #(
        .H_ACTIVE(PHA), .H_BLANK(HB), .V_SYNC(VS),
        .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) p_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_en(1'b1), .src(p_if),
        .post_frame_vsync(p_vs), .post_frame_href(p_href), .post_frame_clken(p_clken),
        .post_img(p_img), .frame_done(p_fd), .underflow(p_uf)
    );

    initial forever begin : pattern_check
        int p_col;
        @(negedge clk);
        if (!rst_n || !p_clken) begin
            p_col = 0;
        end else begin
            check("pattern_pixel", p_img, bars[(p_col / 2 > 7) ? 7 : p_col / 2]);
            p_col++;
        end
        if (rst_n) begin
            check("pattern_src_ready", p_if.src_ready, 0);
            check("pattern_underflow", p_uf, 0);
        end
    end
`endif

    // ---------------- sequence ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input int base, input int budget);
        int k = 0;
        while (fd_total <= base && k < budget) begin tick(1); k++; end
        check("frame_done_seen", (fd_total > base), 1);
    endtask

    task automatic wait_href(input int budget);
        int k = 0;
        while (!href && k < budget) begin tick(1); k++; end
        check("href_seen", href, 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int k = 0;
        while (vs_rises < target && k < budget) begin tick(1); k++; end
        check("vsync_rise_seen", (vs_rises >= target), 1);
    endtask

    initial begin : main
        int b_fd, b_pix, b_uf, b_vs, b_rise;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single frame, source always valid, data 1..12
        b_fd = fd_total; b_pix = pix_total; b_uf = uf_total; b_vs = vs_high; b_rise = vs_rises;
        enable = 1'b1;
        tick(2);
        enable = 1'b0;
        wait_fd(b_fd, 3 * FRAME);
        tick(2 * HT);
        check("t1_vsync_cycles", vs_high - b_vs, HT * VS);
        check("t1_pixel_count", pix_total - b_pix, HA * VA);
        check("t1_last_pixel", last_pix, HA * VA);
        check("t1_no_underflow", uf_total - b_uf, 0);
        check("t1_frame_done_offset", fd_cyc - rise_last, FRAME - 1);
        check("t1_single_vsync", vs_rises - b_rise, 1);

        // Underflow on the 3rd pixel of the first active line
        b_fd = fd_total; b_pix = pix_total; b_uf = uf_total;
        drop_idx = slot_cnt + 2;
        valid_mode = 2;
        enable = 1'b1;
        tick(2);
        enable = 1'b0;
        wait_fd(b_fd, 3 * FRAME);
        tick(2 * HT);
        check("t2_underflow_count", uf_total - b_uf, 1);
        check("t2_pixel_count", pix_total - b_pix, HA * VA);
        check("t2_last_pixel", last_pix, 2 * HA * VA - 1);
        valid_mode = 0;

        // Enable dropped during ACTIVE: frame completes, then idle
        b_fd = fd_total; b_pix = pix_total; b_rise = vs_rises; b_vs = vs_high;
        enable = 1'b1;
        wait_href(3 * FRAME);
        enable = 1'b0;
        wait_fd(b_fd, 3 * FRAME);
        tick(FRAME + HT);
        check("t3_single_vsync", vs_rises - b_rise, 1);
        check("t3_vsync_cycles", vs_high - b_vs, HT * VS);
        check("t3_pixel_count", pix_total - b_pix, HA * VA);
        check("t3_idle_vsync", vsync, 0);
        check("t3_idle_src_ready", src_if.src_ready, 0);

        // Reset in the middle of an active line
        enable = 1'b1;
        wait_href(3 * FRAME);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_vsync", vsync, 0);
        check("t4_href", href, 0);
        check("t4_clken", clken, 0);
        check("t4_img", img, 0);
        check("t4_frame_done", fd, 0);
        check("t4_underflow", uf, 0);
        check("t4_src_ready", src_if.src_ready, 0);
        tick(2);
        b_rise = vs_rises;
        b_fd = cyc;
        rst_n = 1'b1;
        wait_rises(b_rise + 1, 4 * HT);
        check("t4_vsync_latency", rise_last - b_fd, 2);

        // Back-to-back frames with random source gaps
        valid_mode = 1;
        wait_rises(b_rise + 3, 4 * FRAME);
        check("t5_frame_period", rise_last - rise_prev, FRAME);
        enable = 1'b0;
        wait_fd(fd_total, 2 * FRAME);
        tick(FRAME);
        check("scoreboard_drained", exp_q.size(), 0);
        check("t5_idle_vsync", vsync, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
